// File: rtl/riscv_pkg.sv
// Shared RISC-V core types: fetch FSM states, NOP encoding and the fetch-queue entry.
package riscv_pkg;

    localparam int unsigned XLEN      = 32;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     instr;
    } fetch_entry_t;

endpackage

// File: rtl/riscv_fetch_if.sv
// Fetch-stage bus bundle: imem request/response, redirect and decode handshake.
// o_fetch_misalign exists only when RISCV_FETCH_MISALIGN_CHECK_EN is defined.
interface riscv_fetch_if #(
    parameter int unsigned XLEN = riscv_pkg::XLEN
);
    logic            o_fetch_imem_req;
    logic [XLEN-1:0] o_fetch_imem_addr;
    logic            i_fetch_imem_gnt;
    logic            i_fetch_imem_rvalid;
    logic [31:0]     i_fetch_imem_rdata;
    logic            i_fetch_redirect;
    logic [XLEN-1:0] i_fetch_redirect_pc;
    logic            o_fetch_valid;
    logic [31:0]     o_fetch_instr;
    logic [XLEN-1:0] o_fetch_pc;
    logic            i_fetch_ready;
`ifdef RISCV_FETCH_MISALIGN_CHECK_EN
    logic            o_fetch_misalign;

    modport master (
        output o_fetch_imem_req, o_fetch_imem_addr, o_fetch_valid, o_fetch_instr,
               o_fetch_pc, o_fetch_misalign,
        input  i_fetch_imem_gnt, i_fetch_imem_rvalid, i_fetch_imem_rdata,
               i_fetch_redirect, i_fetch_redirect_pc, i_fetch_ready
    );
    modport slave (
        input  o_fetch_imem_req, o_fetch_imem_addr, o_fetch_valid, o_fetch_instr,
               o_fetch_pc, o_fetch_misalign,
        output i_fetch_imem_gnt, i_fetch_imem_rvalid, i_fetch_imem_rdata,
               i_fetch_redirect, i_fetch_redirect_pc, i_fetch_ready
    );
`else
    modport master (
        output o_fetch_imem_req, o_fetch_imem_addr, o_fetch_valid, o_fetch_instr,
               o_fetch_pc,
        input  i_fetch_imem_gnt, i_fetch_imem_rvalid, i_fetch_imem_rdata,
               i_fetch_redirect, i_fetch_redirect_pc, i_fetch_ready
    );
    modport slave (
        input  o_fetch_imem_req, o_fetch_imem_addr, o_fetch_valid, o_fetch_instr,
               o_fetch_pc,
        output i_fetch_imem_gnt, i_fetch_imem_rvalid, i_fetch_imem_rdata,
               i_fetch_redirect, i_fetch_redirect_pc, i_fetch_ready
    );
`endif
endinterface

// File: rtl/riscv_fetch_fifo.sv
// Small synchronous FIFO with flush and occupancy count; used for the fetch queue and PC FIFO.
module riscv_fetch_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 32
) (
    input  logic                       i_fifo_clk,
    input  logic                       i_fifo_rstn,
    input  logic                       i_fifo_push,
    input  logic [WIDTH-1:0]           i_fifo_din,
    input  logic                       i_fifo_pop,
    input  logic                       i_fifo_flush,
    output logic [WIDTH-1:0]           o_fifo_dout,
    output logic [$clog2(DEPTH+1)-1:0] o_fifo_count
);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr, wr_ptr;
    logic [CW-1:0]    count;
    logic             do_push, do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign do_pop  = i_fifo_pop && (count != '0);
    assign do_push = i_fifo_push && ((count != CW'(DEPTH)) || do_pop);

    always_ff @(posedge i_fifo_clk or negedge i_fifo_rstn) begin
        if (!i_fifo_rstn) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (i_fifo_flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_inc(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge i_fifo_clk) begin
        if (do_push && !i_fifo_flush) mem[wr_ptr] <= i_fifo_din;
    end

    assign o_fifo_dout  = mem[rd_ptr];
    assign o_fifo_count = count;

endmodule

// File: rtl/riscv_fetch.sv
// Instruction-fetch stage: PC ownership, credit-limited imem requests, fetch queue, redirect flush.
// Optional misaligned-redirect trap: define RISCV_FETCH_MISALIGN_CHECK_EN.
module riscv_fetch
    import riscv_pkg::*;
#(
    parameter int unsigned     XLEN     = riscv_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int unsigned     FQ_DEPTH = 2
) (
    input  logic          i_fetch_clk,
    input  logic          i_fetch_rstn,
    riscv_fetch_if.master bus
);
    localparam int unsigned CW = $clog2(FQ_DEPTH + 1);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d, redir_pc, pcf_head;
    logic [CW-1:0]   live, drop_q, drop_d, qcnt;
    logic [CW:0]     live_qcnt, live_drop;
    logic            req, grant, rv_drop, rv_keep, hs, valid;
    fetch_entry_t    q_din, q_head;
`ifdef RISCV_FETCH_MISALIGN_CHECK_EN
    logic            misalign_q, misalign_d;
    assign redir_pc = bus.i_fetch_redirect_pc;
`else
    assign redir_pc = bus.i_fetch_redirect_pc & ~XLEN'(3);
`endif

    // live is the PC FIFO occupancy: it grows on kept grants, shrinks on kept responses, flushes on redirect.
    assign live_qcnt = {1'b0, live} + {1'b0, qcnt};
    assign live_drop = {1'b0, live} + {1'b0, drop_q};
    assign req       = (state_q == RUN) && (live_qcnt < (CW+1)'(FQ_DEPTH))
                                        && (live_drop < (CW+1)'(FQ_DEPTH));
    assign grant     = req && bus.i_fetch_imem_gnt;
    assign rv_drop   = bus.i_fetch_imem_rvalid && (drop_q != '0);
    assign rv_keep   = bus.i_fetch_imem_rvalid && !rv_drop && !bus.i_fetch_redirect;
    assign valid     = (qcnt != '0);
    assign hs        = valid && bus.i_fetch_ready;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        drop_d  = drop_q;
`ifdef RISCV_FETCH_MISALIGN_CHECK_EN
        misalign_d = misalign_q;
`endif
        if (state_q == BOOT) state_d = RUN;
        if (bus.i_fetch_redirect) begin
            pc_d   = redir_pc;
            // Every in-flight response, including one granted now, becomes a discard; an rvalid now consumes one.
            drop_d = drop_q + live + CW'(grant) - CW'(bus.i_fetch_imem_rvalid);
`ifdef RISCV_FETCH_MISALIGN_CHECK_EN
            if (redir_pc[1:0] != 2'b00) begin
                state_d    = HALT;
                misalign_d = 1'b1;
            end else begin
                state_d    = RUN;
                misalign_d = 1'b0;
            end
`endif
        end else begin
            if (grant) pc_d = pc_q + XLEN'(4);
            drop_d = drop_q - CW'(rv_drop);
        end
    end

    always_ff @(posedge i_fetch_clk or negedge i_fetch_rstn) begin
        if (!i_fetch_rstn) begin
            state_q <= BOOT;
            pc_q    <= RESET_PC;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            drop_q  <= drop_d;
        end
    end

`ifdef RISCV_FETCH_MISALIGN_CHECK_EN
    always_ff @(posedge i_fetch_clk or negedge i_fetch_rstn) begin
        if (!i_fetch_rstn) misalign_q <= 1'b0;
        else               misalign_q <= misalign_d;
    end
    assign bus.o_fetch_misalign = misalign_q;
`endif

    riscv_fetch_fifo #(.DEPTH(FQ_DEPTH), .WIDTH(XLEN)) u_pc_fifo (
        .i_fifo_clk   (i_fetch_clk),
        .i_fifo_rstn  (i_fetch_rstn),
        .i_fifo_push  (grant && !bus.i_fetch_redirect),
        .i_fifo_din   (pc_q),
        .i_fifo_pop   (rv_keep),
        .i_fifo_flush (bus.i_fetch_redirect),
        .o_fifo_dout  (pcf_head),
        .o_fifo_count (live)
    );

    always_comb begin
        q_din       = '0;
        q_din.pc    = pcf_head;
        q_din.instr = bus.i_fetch_imem_rdata;
    end

    riscv_fetch_fifo #(.DEPTH(FQ_DEPTH), .WIDTH($bits(fetch_entry_t))) u_queue (
        .i_fifo_clk   (i_fetch_clk),
        .i_fifo_rstn  (i_fetch_rstn),
        .i_fifo_push  (rv_keep),
        .i_fifo_din   (q_din),
        .i_fifo_pop   (hs),
        .i_fifo_flush (bus.i_fetch_redirect),
        .o_fifo_dout  (q_head),
        .o_fifo_count (qcnt)
    );

    assign bus.o_fetch_imem_req  = req;
    assign bus.o_fetch_imem_addr = pc_q;
    assign bus.o_fetch_valid     = valid;
    assign bus.o_fetch_instr     = valid ? q_head.instr : '0;
    assign bus.o_fetch_pc        = valid ? q_head.pc : '0;

endmodule
